ip1_shift_chain_engine: RTL and testbench

- Parametrised test sequencer that shifts a pattern through one DUT serial chain (config chain or scan chain), selected per run, then compares the chain output against an expected bitstream.
- Chain length and pass count are runtime-programmable. Multi-pass runs and a saturating mismatch counter are included.
- Sits beside the other ip1 test sequencers and is selected by `enable`. It consumes the shared fast-clock slot counter and the shared pattern shift register.

---
 rtl/ip1_shift_pkg.sv | 22 ++
 rtl/ip1_shift_chain_engine_tick.sv | 19 +
 rtl/ip1_shift_chain_engine.sv | 184 ++++++++++++++++++
 tb/tb_ip1_shift_chain_engine.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ip1_shift_pkg.sv
// Shared types and default widths for the ip1 shift-chain test sequencer.
package ip1_shift_pkg;

  localparam int CNT_W_DEF   = 14;
  localparam int DELAY_W_DEF = 7;
  localparam int PASS_W_DEF  = 4;
  localparam int ERR_W_DEF   = 16;

  // Sequencer state encoding (visible on the state port).
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_DELAY  = 3'd1;
  localparam state_t ST_RSTN   = 3'd2;
  localparam state_t ST_SHIFT  = 3'd3;
  localparam state_t ST_RELOAD = 3'd4;
  localparam state_t ST_DONE   = 3'd5;
  localparam state_t ST_ABORT  = 3'd6;

  typedef enum logic {CONFIG_CHAIN = 1'b0, SCAN_CHAIN = 1'b1} chain_target_t;
  typedef enum logic {SHIFT_REG = 1'b0, PARALLEL_OUT = 1'b1} load_mode_t;

endpackage

// File: rtl/ip1_shift_chain_engine_tick.sv
// Slot decoder: tick marks the configured phase of the fast-clock slot
// counter, pre marks the phase two cycles earlier (wrapping modulo 2^DELAY_W).
module ip1_slot_tick #(
  parameter int DELAY_W = 7
) (
  input  logic [DELAY_W-1:0] cnt_i,
  input  logic [DELAY_W-1:0] delay_i,
  output logic               tick_o,
  output logic               pre_o
);

  logic [DELAY_W-1:0] pre_slot;

  // Natural width truncation gives the wrap-around subtraction.
  assign pre_slot = delay_i - DELAY_W'(2);
  assign tick_o   = (cnt_i == delay_i);
  assign pre_o    = (cnt_i == pre_slot);

endmodule

// File: rtl/ip1_shift_chain_engine.sv
// Shift-chain test sequencer: loads a pattern, pulses DUT reset, shifts the
// pattern through the selected chain for N passes and counts mismatches.
module ip1_shift_chain_engine
  import ip1_shift_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DELAY_W = DELAY_W_DEF,
  parameter int PASS_W  = PASS_W_DEF,
  parameter int ERR_W   = ERR_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               start_re,
  input  logic               abort,
  input  logic [DELAY_W-1:0] clk_counter_fc,
  input  logic [DELAY_W-1:0] test_delay,
  input  logic               test_mask_reset_not,
  input  logic               cfg_target,
  input  logic [CNT_W-1:0]   cfg_shift_len,
  input  logic [CNT_W-1:0]   cfg_cmp_start,
  input  logic [PASS_W-1:0]  cfg_passes,
  input  logic               fast_config_clk,
  input  logic               pat_bit0,
  input  logic               exp_bit,
  input  logic               dut_chain_out,
  output logic               pat_load,
  output logic               pat_shift,
  output logic               o_config_clk,
  output logic               o_reset_not,
  output logic               o_config_in,
  output logic               o_config_load,
  output logic               o_scan_in,
  output logic               o_scan_load,
  output logic               status_done,
  output logic               status_err,
  output logic               status_aborted,
  output logic [ERR_W-1:0]   err_cnt,
  output logic [2:0]         state
);

  state_t            state_q;
  logic              pat_load_q, pat_shift_q, rstn_q, data_q, load_q;
  logic              done_q, aborted_q;
  logic [ERR_W-1:0]  err_q, err_d;
  chain_target_t     tgt_q;
  logic [CNT_W-1:0]  len_q, cmp_q, shift_cnt_q;
  logic [PASS_W-1:0] passes_q, pass_cnt_q;
  logic              tick, pre, last_shift, more_passes, mismatch;

  ip1_slot_tick #(.DELAY_W(DELAY_W)) u_tick (
    .cnt_i   (clk_counter_fc),
    .delay_i (test_delay),
    .tick_o  (tick),
    .pre_o   (pre)
  );

  assign err_d       = (&err_q) ? err_q : err_q + ERR_W'(1);
  assign last_shift  = (shift_cnt_q == len_q - CNT_W'(1));
  assign more_passes = (pass_cnt_q < passes_q - PASS_W'(1));
  assign mismatch    = (shift_cnt_q >= cmp_q) && (dut_chain_out != exp_bit);

  // Sequencer: reset, then enable gating, then abort priority, then per-state work.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pat_load_q  <= 1'b0;
      pat_shift_q <= 1'b0;
      rstn_q      <= 1'b1;
      data_q      <= 1'b0;
      load_q      <= PARALLEL_OUT;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      err_q       <= '0;
      tgt_q       <= CONFIG_CHAIN;
      len_q       <= '0;
      cmp_q       <= '0;
      passes_q    <= '0;
      shift_cnt_q <= '0;
      pass_cnt_q  <= '0;
    end else if (!enable) begin
      // Deselected: drop back to IDLE but freeze everything else.
      state_q <= ST_IDLE;
    end else if (abort && (state_q inside {ST_DELAY, ST_RSTN, ST_SHIFT, ST_RELOAD, ST_DONE})) begin
      state_q     <= ST_ABORT;
      pat_load_q  <= 1'b0;
      pat_shift_q <= 1'b0;
      rstn_q      <= 1'b1;
      data_q      <= 1'b0;
      load_q      <= PARALLEL_OUT;
      aborted_q   <= 1'b1;
      done_q      <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          pat_load_q  <= 1'b0;
          pat_shift_q <= 1'b0;
          rstn_q      <= 1'b1;
          data_q      <= 1'b0;
          load_q      <= PARALLEL_OUT;
          if (start_re) begin
            tgt_q       <= chain_target_t'(cfg_target);
            len_q       <= (cfg_shift_len == '0) ? CNT_W'(1) : cfg_shift_len;
            cmp_q       <= cfg_cmp_start;
            passes_q    <= (cfg_passes == '0) ? PASS_W'(1) : cfg_passes;
            shift_cnt_q <= '0;
            pass_cnt_q  <= '0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            err_q       <= '0;
            pat_load_q  <= 1'b1;
            state_q     <= ST_DELAY;
          end
        end
        ST_DELAY: begin
          pat_load_q <= 1'b1;
          if (tick) begin
            pat_load_q <= 1'b0;
            rstn_q     <= test_mask_reset_not;
            load_q     <= SHIFT_REG;
            state_q    <= ST_RSTN;
          end
        end
        ST_RSTN: begin
          if (tick) begin
            rstn_q  <= 1'b1;
            data_q  <= pat_bit0;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          data_q      <= pat_bit0;
          pat_shift_q <= pre;
          if (tick) begin
            if (mismatch) err_q <= err_d;
            if (!last_shift) begin
              shift_cnt_q <= shift_cnt_q + CNT_W'(1);
            end else if (more_passes) begin
              pat_load_q  <= 1'b1;
              pass_cnt_q  <= pass_cnt_q + PASS_W'(1);
              shift_cnt_q <= '0;
              state_q     <= ST_RELOAD;
            end else begin
              load_q  <= PARALLEL_OUT;
              data_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end
          end
        end
        ST_RELOAD: begin
          // One-cycle reload pulse; chain stays in shift mode, no new DUT reset.
          pat_load_q  <= 1'b0;
          pat_shift_q <= 1'b0;
          data_q      <= pat_bit0;
          if (tick) state_q <= ST_SHIFT;
        end
        ST_DONE: begin
          load_q  <= PARALLEL_OUT;
          data_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Only the selected chain is driven; the other sits in parallel mode with data low.
  assign o_config_in    = (tgt_q == CONFIG_CHAIN) ? data_q : 1'b0;
  assign o_config_load  = (tgt_q == CONFIG_CHAIN) ? load_q : 1'b1;
  assign o_scan_in      = (tgt_q == SCAN_CHAIN)   ? data_q : 1'b0;
  assign o_scan_load    = (tgt_q == SCAN_CHAIN)   ? load_q : 1'b1;

  assign o_config_clk   = fast_config_clk;
  assign o_reset_not    = rstn_q;
  assign pat_load       = pat_load_q;
  assign pat_shift      = pat_shift_q;
  assign status_done    = done_q;
  assign status_aborted = aborted_q;
  assign status_err     = (err_q != '0);
  assign err_cnt        = err_q;
  assign state          = state_q;

endmodule

// File: tb/tb_ip1_shift_chain_engine.sv
// Bench for ip1_shift_chain_engine: free-running slot counter, shared pattern
// register, mismatch injection indexed by slot ticks, reference counts per run.
module tb_ip1_shift_chain_engine;

  logic        clk = 1'b0, reset = 1'b1, enable = 1'b0, start_re = 1'b0, abort = 1'b0;
  logic [6:0]  fc_cnt = 7'd0, test_delay = 7'd10;
  logic        mask_rn = 1'b0, cfg_target = 1'b0;
  logic [13:0] cfg_len = 14'd8, cfg_cmp = 14'd0;
  logic [3:0]  cfg_passes = 4'd1;
  logic [31:0] pat_val = 32'h0, patr = 32'h0;
  logic [15:0] mis_mask = 16'h0;
  logic        fast_config_clk, pat_bit0, exp_bit, dut_out, dut_out2, inj;

  logic        pat_load, pat_shift, o_config_clk, o_reset_not, o_config_in, o_config_load;
  logic        o_scan_in, o_scan_load, status_done, status_err, status_aborted;
  logic [15:0] err_cnt;
  logic [2:0]  state;
  logic        pl2, ps2, cc2, rn2, ci2, cl2, si2, sl2, sd2, se2, sa2;
  logic [1:0]  err2;
  logic [2:0]  st2;

  int tk = 0, len_e = 1, passes_e = 1;
  logic run_tk = 1'b0, data_chk = 1'b0, pl_prev = 1'b0;
  int n_shift = 0, n_shift_bad = 0, n_load_rise = 0, n_rst_low = 0, n_unsel = 0, n_data_bad = 0;
  int s_shift, s_shift_bad, s_load_rise, s_rst_low, s_unsel, s_data_bad;
  int n_chk = 0, n_pass = 0, n_fail = 0;

  localparam logic [12:0] IDLE_VEC = 13'b00_1_0_1_0_1_000_000;

  always #5 clk = ~clk;
  always @(posedge clk) fc_cnt <= fc_cnt + 7'd1;
  assign fast_config_clk = fc_cnt[0];

  // Shared pattern register the engine drives through pat_load / pat_shift.
  always @(posedge clk)
    if (pat_load) patr <= pat_val;
    else if (pat_shift) patr <= {1'b0, patr[31:1]};
  assign pat_bit0 = patr[0];
  assign exp_bit  = patr[1];

  // Ticks seen since the run started (start edge itself excluded).
  always @(posedge clk)
    if (!run_tk) tk <= 0;
    else if (fc_cnt == test_delay) tk <= tk + 1;

  // Tick n = tk+1 is next; ticks 1,2 are reset phase, then passes of len+1 ticks
  // (len shifts plus one reload tick). Inject a mismatch on masked shift indices.
  int q, r;
  always_comb begin
    q = tk - 2;
    r = 0;
    inj = 1'b0;
    if (run_tk && q >= 0) begin
      r = q % (len_e + 1);
      if (r < len_e) inj = mis_mask[r[3:0]];
    end
  end
  assign dut_out  = exp_bit ^ inj;
  assign dut_out2 = ~exp_bit;

  ip1_shift_chain_engine dut (
    .clk(clk), .reset(reset), .enable(enable), .start_re(start_re), .abort(abort),
    .clk_counter_fc(fc_cnt), .test_delay(test_delay), .test_mask_reset_not(mask_rn),
    .cfg_target(cfg_target), .cfg_shift_len(cfg_len), .cfg_cmp_start(cfg_cmp),
    .cfg_passes(cfg_passes), .fast_config_clk(fast_config_clk), .pat_bit0(pat_bit0),
    .exp_bit(exp_bit), .dut_chain_out(dut_out), .pat_load(pat_load), .pat_shift(pat_shift),
    .o_config_clk(o_config_clk), .o_reset_not(o_reset_not), .o_config_in(o_config_in),
    .o_config_load(o_config_load), .o_scan_in(o_scan_in), .o_scan_load(o_scan_load),
    .status_done(status_done), .status_err(status_err), .status_aborted(status_aborted),
    .err_cnt(err_cnt), .state(state)
  );

  // Narrow error counter fed a permanent mismatch, to exercise saturation.
  ip1_shift_chain_engine #(.ERR_W(2)) dut_sat (
    .clk(clk), .reset(reset), .enable(enable), .start_re(start_re), .abort(abort),
    .clk_counter_fc(fc_cnt), .test_delay(test_delay), .test_mask_reset_not(mask_rn),
    .cfg_target(cfg_target), .cfg_shift_len(cfg_len), .cfg_cmp_start(cfg_cmp),
    .cfg_passes(cfg_passes), .fast_config_clk(fast_config_clk), .pat_bit0(pat_bit0),
    .exp_bit(exp_bit), .dut_chain_out(dut_out2), .pat_load(pl2), .pat_shift(ps2),
    .o_config_clk(cc2), .o_reset_not(rn2), .o_config_in(ci2), .o_config_load(cl2),
    .o_scan_in(si2), .o_scan_load(sl2), .status_done(sd2), .status_err(se2),
    .status_aborted(sa2), .err_cnt(err2), .state(st2)
  );

  // Running observations: shift-pulse timing, reload pulses, reset width,
  // idle chain, and the data bit launched after each tick.
  int dq, dp, dr;
  always @(negedge clk) begin
    if (pat_shift) begin
      n_shift++;
      // pulse is registered from pre (delay-2), so it shows while the counter reads delay-1
      if (fc_cnt !== 7'(test_delay - 7'd2 + 7'd1)) n_shift_bad++;
    end
    if (pat_load && !pl_prev) n_load_rise++;
    pl_prev = pat_load;
    if (!o_reset_not) n_rst_low++;
    if (cfg_target ? (o_config_in !== 1'b0 || o_config_load !== 1'b1)
                   : (o_scan_in !== 1'b0 || o_scan_load !== 1'b1)) n_unsel++;
    if (data_chk && run_tk && tk >= 2 && fc_cnt == 7'(test_delay + 7'd1)) begin
      dq = tk - 2;
      dp = dq / (len_e + 1);
      dr = dq % (len_e + 1);
      if (dp < passes_e && dr < len_e)
        if ((cfg_target ? o_scan_in : o_config_in) !== pat_val[dr]) n_data_bad++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic start_run(input logic tgt, input int len, input int cmp, input int passes,
                           input logic [6:0] dly, input logic [15:0] mm, input logic dchk);
    @(negedge clk);
    cfg_target = tgt; cfg_len = 14'(len); cfg_cmp = 14'(cmp); cfg_passes = 4'(passes);
    test_delay = dly; mis_mask = mm; data_chk = dchk;
    len_e    = (len == 0) ? 1 : len;
    passes_e = (passes == 0) ? 1 : passes;
    s_shift = n_shift; s_shift_bad = n_shift_bad; s_load_rise = n_load_rise;
    s_rst_low = n_rst_low; s_unsel = n_unsel; s_data_bad = n_data_bad;
    start_re = 1'b1;
    @(negedge clk);
    start_re = 1'b0;
    run_tk   = 1'b1;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (status_done !== 1'b1 && k < 20000) begin @(negedge clk); k++; end
    chk({tag, "_done"}, status_done, 1);
    chk({tag, "_state_done"}, state, 5);
    run_tk = 1'b0; data_chk = 1'b0;
  endtask

  task automatic wait_tk(input int n, input string tag);
    int k = 0;
    while (tk < n && k < 20000) begin @(negedge clk); k++; end
    chk(tag, tk, n);
  endtask

  initial begin
    pat_val = $urandom;
    enable = 1'b1;
    reset  = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {pat_load, pat_shift, o_reset_not, o_config_in, o_config_load,
        o_scan_in, o_scan_load, status_done, status_err, status_aborted, state}, IDLE_VEC);
    chk("reset_err", err_cnt, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("config_clk", o_config_clk, fast_config_clk);

    // Basic config-chain run, no mismatches.
    start_run(1'b0, 8, 0, 1, 7'd10, 16'h0000, 1'b1);
    wait_done("basic");
    chk("basic_cfg_load", o_config_load, 1);
    chk("basic_cfg_in", o_config_in, 0);
    chk("basic_rst_slot", n_rst_low - s_rst_low, 128);
    chk("basic_shifts", n_shift - s_shift, 8);
    chk("basic_shift_align", n_shift_bad - s_shift_bad, 0);
    chk("basic_err", err_cnt, 0);
    chk("basic_status_err", status_err, 0);
    chk("basic_loads", n_load_rise - s_load_rise, 1);
    chk("basic_data", n_data_bad - s_data_bad, 0);
    chk("basic_scan_idle", n_unsel - s_unsel, 0);
    chk("sat_err", err2, 3);
    @(negedge clk);
    chk("basic_back_idle", state, 0);

    // Scan chain, three passes, mismatches at shifts 2, 5, 9 with compare from 4.
    pat_val = $urandom;
    start_run(1'b1, 16, 4, 3, 7'd10, 16'h0224, 1'b1);
    wait_done("scan");
    chk("scan_err", err_cnt, 6);
    chk("scan_status_err", status_err, 1);
    chk("scan_reloads", n_load_rise - s_load_rise - 1, 2);
    chk("scan_shifts", n_shift - s_shift, 48);
    chk("scan_cfg_idle", n_unsel - s_unsel, 0);
    chk("scan_data", n_data_bad - s_data_bad, 0);
    chk("scan_load_done", o_scan_load, 1);

    // Wrapped pre slot (delay 1 -> pre at 127), zero length and zero passes.
    start_run(1'b0, 0, 0, 0, 7'd1, 16'h0001, 1'b1);
    wait_done("wrap");
    chk("wrap_shifts", n_shift - s_shift, 1);
    chk("wrap_shift_align", n_shift_bad - s_shift_bad, 0);
    chk("wrap_err", err_cnt, 1);
    chk("wrap_data", n_data_bad - s_data_bad, 0);

    // Abort during shift 5, landing on a tick cycle.
    start_run(1'b0, 16, 0, 1, 7'd10, 16'h0000, 1'b0);
    wait_tk(7, "abort_reach");
    for (int k = 0; k < 200 && fc_cnt != test_delay; k++) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    chk("abort_state", state, 6);
    abort = 1'b0;
    @(negedge clk);
    chk("abort_idle", state, 0);
    chk("abort_flag", status_aborted, 1);
    chk("abort_done", status_done, 1);
    chk("abort_rstn", o_reset_not, 1);
    chk("abort_loads", {o_config_load, o_scan_load}, 2'b11);
    run_tk = 1'b0;

    // Start ignored mid-shift, then enable dropped.
    start_run(1'b0, 16, 0, 1, 7'd10, 16'h0000, 1'b0);
    wait_tk(5, "en_reach");
    start_re = 1'b1;
    @(negedge clk);
    start_re = 1'b0;
    chk("start_ignored", state, 3);
    chk("start_ignored_load", pat_load, 0);
    enable = 1'b0;
    @(negedge clk);
    chk("en_low_state", state, 0);
    chk("en_low_hold_load", o_config_load, 0);
    repeat (300) @(negedge clk);
    chk("en_low_still_held", {o_config_load, o_reset_not, status_done}, 3'b010);
    enable = 1'b1;
    @(negedge clk);
    chk("en_back_default", o_config_load, 1);
    run_tk = 1'b0;

    // Synchronous reset in the middle of a scan run.
    start_run(1'b1, 8, 0, 1, 7'd10, 16'h0000, 1'b0);
    wait_tk(4, "rst_reach");
    reset = 1'b1;
    @(negedge clk);
    chk("midrun_reset", {pat_load, pat_shift, o_reset_not, o_config_in, o_config_load,
        o_scan_in, o_scan_load, status_done, status_err, status_aborted, state}, IDLE_VEC);
    reset = 1'b0;
    run_tk = 1'b0;

    // Randomised runs against the counting model.
    for (int it = 0; it < 4; it++) begin
      int len, cmp, passes, e;
      logic tgt;
      logic [15:0] mm;
      tgt    = 1'($urandom_range(0, 1));
      len    = $urandom_range(1, 12);
      cmp    = $urandom_range(0, len);
      passes = $urandom_range(1, 3);
      mm     = 16'($urandom);
      pat_val = $urandom;
      start_run(tgt, len, cmp, passes, 7'($urandom_range(0, 127)), mm, 1'b1);
      wait_done("rnd");
      e = 0;
      for (int i = cmp; i < len; i++) if (mm[i]) e++;
      e = e * passes;
      chk("rnd_err", err_cnt, e);
      chk("rnd_status_err", status_err, (e != 0));
      chk("rnd_shifts", n_shift - s_shift, passes * len);
      chk("rnd_shift_align", n_shift_bad - s_shift_bad, 0);
      chk("rnd_loads", n_load_rise - s_load_rise, passes);
      chk("rnd_unsel", n_unsel - s_unsel, 0);
      chk("rnd_data", n_data_bad - s_data_bad, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
